// File: rtl/autobus_pkg.sv
// autobus_pkg: shared types and helpers for the autobus traffic generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package autobus_pkg;

  localparam int LEN_W = 16;

  typedef enum logic {
    SEND = 1'b0,
    GAP  = 1'b1
  } state_t;

  // Index of the last item for a programmed length; a length of 0 behaves as 1.
  function automatic logic [LEN_W-1:0] last_idx(input logic [LEN_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

endpackage

// File: rtl/autobus_cnt.sv
// autobus_cnt: up-counter that wraps to 0 after reaching its limit, with terminal-count flag.
// Latency: count updates on the edge where inc is high; tc is combinational from count/limit.
// Backpressure: none; counts only when inc is asserted.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   inc       : advance the counter this cycle
//   limit     : terminal value; tc is high when count has reached (or passed) it
//   count     : current value
//   tc        : terminal-count flag
module autobus_cnt
  import autobus_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [LEN_W-1:0] limit,
  output logic [LEN_W-1:0] count,
  output logic             tc
);

  // ">=" so that a limit lowered at a boundary below the current count still terminates.
  assign tc = (count >= limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/autobus_gen.sv
// autobus_gen: free-running packet/frame test-traffic source with programmable inter-packet gap.
// Latency: rdy high at edge n -> word presented (dav=1) in the cycle after edge n; all outputs registered.
// Backpressure: rdy low stalls word emission with all state held; the gap counts regardless of rdy.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   sop_len       : packet length in words (0 behaves as 1), sampled at packet start
//   sof_len       : frame length in packets (0 behaves as 1), sampled at packet start
//   pkt_interval  : idle cycles after every packet (0 = back-to-back), sampled at gap start
//   rdy           : downstream ready
//   sop/eop       : first/last word of packet, qualified by dav
//   sof/eof       : first word of first packet / last word of last packet of a frame
//   dat           : word index within packet, saturating at all-ones
//   dav           : data valid
module autobus_gen
  import autobus_pkg::*;
#(
  parameter int DWID = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] sop_len,
  input  logic [LEN_W-1:0] sof_len,
  input  logic [LEN_W-1:0] pkt_interval,
  input  logic             rdy,
  output logic             sop,
  output logic             eop,
  output logic             sof,
  output logic             eof,
  output logic [DWID-1:0]  dat,
  output logic             dav
);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] wcnt, pcnt, gcnt_unused;
  logic [LEN_W-1:0] wlim_q, flim_q, glim_q;
  logic [LEN_W-1:0] wlim, flim;
  logic             wtc, ptc, gtc;
  logic             emit, pkt_end, first_word;
  logic             sop_nxt, eop_nxt, sof_nxt, eof_nxt, dav_nxt;
  logic [DWID-1:0]  dat_nxt;

  assign first_word = (wcnt == '0);
  assign emit       = (state == SEND) && rdy;
  assign pkt_end    = emit && wtc;

  // Lengths take their live input value on the first word and are held for the rest of the
  // packet, so mid-packet changes only land at the next packet boundary.
  assign wlim = first_word ? last_idx(sop_len) : wlim_q;
  assign flim = first_word ? last_idx(sof_len) : flim_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wlim_q <= '0;
      flim_q <= '0;
      glim_q <= '0;
    end else begin
      if (emit && first_word) begin
        wlim_q <= wlim;
        flim_q <= flim;
      end
      // Only consumed when pkt_interval is non-zero, so the subtraction never underflows in use.
      if (pkt_end) begin
        glim_q <= pkt_interval - 1'b1;
      end
    end
  end

  autobus_cnt u_word (
    .clk   (clk),
    .rst   (rst),
    .inc   (emit),
    .limit (wlim),
    .count (wcnt),
    .tc    (wtc)
  );

  autobus_cnt u_pkt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pkt_end),
    .limit (flim),
    .count (pcnt),
    .tc    (ptc)
  );

  autobus_cnt u_gap (
    .clk   (clk),
    .rst   (rst),
    .inc   (state == GAP),
    .limit (glim_q),
    .count (gcnt_unused),
    .tc    (gtc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEND;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      SEND: if (pkt_end && (pkt_interval != '0)) state_nxt = GAP;
      GAP:  if (gtc) state_nxt = SEND;
    endcase
  end

  // Output logic (values for the output registers)
  always_comb begin
    dav_nxt = emit;
    sop_nxt = emit && first_word;
    eop_nxt = pkt_end;
    sof_nxt = emit && first_word && (pcnt == '0);
    eof_nxt = pkt_end && ptc;
  end

  // Word index saturates instead of wrapping when the packet outgrows the data width.
  if (DWID < LEN_W) begin : g_sat
    localparam logic [LEN_W-1:0] SAT = LEN_W'((1 << DWID) - 1);
    assign dat_nxt = (wcnt > SAT) ? SAT[DWID-1:0] : wcnt[DWID-1:0];
  end else begin : g_ext
    assign dat_nxt = DWID'(wcnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dav <= 1'b0;
      sop <= 1'b0;
      eop <= 1'b0;
      sof <= 1'b0;
      eof <= 1'b0;
      dat <= '0;
    end else begin
      dav <= dav_nxt;
      sop <= sop_nxt;
      eop <= eop_nxt;
      sof <= sof_nxt;
      eof <= eof_nxt;
      if (emit) begin
        dat <= dat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_autobus_gen.sv
// tb_autobus_gen: self-checking bench for autobus_gen (16-bit and 8-bit data instances side by side).
// Latency: n/a.
// Backpressure: rdy driven directly, including random toggling.
module tb_autobus_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sop_len, sof_len, pkt_interval;
  logic        rdy;

  logic        sop16, eop16, sof16, eof16, dav16;
  logic [15:0] dat16;
  logic        sop8, eop8, sof8, eof8, dav8;
  logic [7:0]  dat8;

  always #5 clk = ~clk;

  autobus_gen #(.DWID(16)) dut (
    .clk(clk), .rst(rst), .sop_len(sop_len), .sof_len(sof_len), .pkt_interval(pkt_interval),
    .rdy(rdy), .sop(sop16), .eop(eop16), .sof(sof16), .eof(eof16), .dat(dat16), .dav(dav16)
  );

  autobus_gen #(.DWID(8)) dut8 (
    .clk(clk), .rst(rst), .sop_len(sop_len), .sof_len(sof_len), .pkt_interval(pkt_interval),
    .rdy(rdy), .sop(sop8), .eop(eop8), .sof(sof8), .eof(eof8), .dat(dat8), .dav(dav8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int eff(input int len);
    return (len == 0) ? 1 : len;
  endfunction

  // ---------------- behavioural model ----------------
  // Tracks "which word of which packet comes next" and "how many idle cycles remain".
  bit       started = 1'b0;
  int       m_w, m_p, m_gap, m_L, m_F;
  bit       m_sop, m_eop, m_sof, m_eof;
  bit       e_dav, e_rst;
  bit [3:0] e_flags;
  int       e_dat;

  always @(posedge clk) begin
    started = 1'b1;
    e_rst   = rst;
    if (rst) begin
      m_w = 0; m_p = 0; m_gap = 0;
      e_dav = 1'b0; e_flags = 4'b0; e_dat = 0;
    end else if (m_gap > 0) begin
      m_gap--;
      e_dav = 1'b0; e_flags = 4'b0;
    end else if (rdy) begin
      if (m_w == 0) begin
        m_L = eff(int'(sop_len));
        m_F = eff(int'(sof_len));
      end
      m_sop = (m_w == 0);
      m_eop = (m_w == m_L - 1);
      m_sof = m_sop && (m_p == 0);
      m_eof = m_eop && (m_p >= m_F - 1);
      e_dav   = 1'b1;
      e_dat   = m_w;
      e_flags = {m_sop, m_eop, m_sof, m_eof};
      if (m_eop) begin
        m_w   = 0;
        m_p   = m_eof ? 0 : m_p + 1;
        m_gap = int'(pkt_interval);
      end else begin
        m_w++;
      end
    end else begin
      e_dav = 1'b0; e_flags = 4'b0;
    end
  end

  // ---------------- compare + recorder ----------------
  typedef struct {
    int       cyc;
    int       dat;
    bit [3:0] fl;   // {sop, eop, sof, eof}
  } word_t;

  word_t rec16[$];
  word_t rec8[$];
  int    cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (started) begin
      chk("dav16", dav16, e_dav);
      chk("flags16", {sop16, eop16, sof16, eof16}, e_flags);
      chk("dav8", dav8, e_dav);
      chk("flags8", {sop8, eop8, sof8, eof8}, e_flags);
      if (e_dav || e_rst) begin
        chk("dat16", dat16, e_dat);
        chk("dat8", dat8, (e_dat > 255) ? 255 : e_dat);
      end
      if (dav16) rec16.push_back('{cyc, int'(dat16), {sop16, eop16, sof16, eof16}});
      if (dav8)  rec8.push_back('{cyc, int'(dat8), {sop8, eop8, sof8, eof8}});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic restart(input int sl, input int fl, input int gi);
    rst = 1'b1;
    sop_len = 16'(sl); sof_len = 16'(fl); pkt_interval = 16'(gi);
    rdy = 1'b1;
    step(2);
    rec16.delete();
    rec8.delete();
    rst = 1'b0;
  endtask

  initial begin
    int       bad;
    int       prev;
    int       exp_d[9];
    bit [3:0] exp_f[9];

    rst = 1'b1; rdy = 1'b1;
    sop_len = 16'd256; sof_len = 16'd256; pkt_interval = 16'd256;
    step(3);
    chk("reset_dav", dav16, 0);
    chk("reset_dat", dat16, 0);
    chk("reset_flags", {sop16, eop16, sof16, eof16}, 0);

    // Test 1: 256-word packets, 256-cycle gap
    rec16.delete(); rec8.delete();
    rst = 1'b0;
    step(540);
    chk("t1_count", int'(rec16.size() >= 257), 1);
    if (rec16.size() >= 257) begin
      bad = 0;
      for (int i = 0; i < 256; i++) if (rec16[i].dat != i) bad++;
      chk("t1_seq", bad, 0);
      chk("t1_first_fl", rec16[0].fl, 4'b1010);
      chk("t1_last_dat", rec16[255].dat, 255);
      chk("t1_last_fl", rec16[255].fl, 4'b0100);
      chk("t1_gap", rec16[256].cyc - rec16[255].cyc, 257);
      chk("t1_next_dat", rec16[256].dat, 0);
      chk("t1_next_fl", rec16[256].fl, 4'b1000);
    end

    // Test 2: 4-word packets, 2-packet frames, back-to-back
    restart(4, 2, 0);
    step(20);
    exp_d = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    exp_f = '{4'b1010, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0101, 4'b1010};
    chk("t2_count", int'(rec16.size() >= 9), 1);
    if (rec16.size() >= 9) begin
      for (int i = 0; i < 9; i++) begin
        chk($sformatf("t2_dat[%0d]", i), rec16[i].dat, exp_d[i]);
        chk($sformatf("t2_fl[%0d]", i), rec16[i].fl, exp_f[i]);
      end
      chk("t2_b2b", rec16[8].cyc - rec16[0].cyc, 8);
    end

    // Test 3: random rdy, gap of 5
    restart(7, 3, 5);
    repeat (300) begin
      rdy = 1'($urandom_range(0, 1));
      step(1);
    end
    rdy = 1'b1;
    step(2);
    chk("t3_some_words", int'(rec16.size() > 20), 1);
    bad = 0; prev = -1;
    for (int i = 0; i < rec16.size(); i++) begin
      if (rec16[i].fl[3]) begin
        if (rec16[i].dat != 0) bad++;
        if (i > 0 && (rec16[i].cyc - rec16[i-1].cyc) < 6) bad++;
      end else if (rec16[i].dat != prev + 1) begin
        bad++;
      end
      prev = rec16[i].dat;
    end
    chk("t3_seq", bad, 0);

    // Test 4: zero lengths -> single-word packets and frames
    restart(0, 0, 0);
    step(12);
    chk("t4_count", int'(rec16.size() >= 10), 1);
    bad = 0;
    for (int i = 0; i < rec16.size(); i++)
      if (rec16[i].dat != 0 || rec16[i].fl != 4'b1111) bad++;
    chk("t4_all", bad, 0);

    // Test 5: 300-word packet, 8-bit saturation
    restart(300, 1, 3);
    step(310);
    chk("t5_count", int'(rec8.size() >= 300 && rec16.size() >= 300), 1);
    if (rec8.size() >= 300 && rec16.size() >= 300) begin
      chk("t5_first_fl", rec8[0].fl, 4'b1010);
      chk("t5_d8_255", rec8[255].dat, 255);
      chk("t5_d8_256", rec8[256].dat, 255);
      chk("t5_d8_299", rec8[299].dat, 255);
      chk("t5_fl_298", rec8[298].fl, 4'b0000);
      chk("t5_fl_299", rec8[299].fl, 4'b0101);
      chk("t5_d16_299", rec16[299].dat, 299);
    end

    // Test 6: reset in the middle of a packet
    restart(10, 2, 0);
    step(15);
    rst = 1'b1;
    step(2);
    chk("t6_rst_dav", dav16, 0);
    chk("t6_rst_fl", {sop16, eop16, sof16, eof16}, 0);
    chk("t6_rst_dat", dat16, 0);
    rec16.delete(); rec8.delete();
    rst = 1'b0;
    step(3);
    chk("t6_count", int'(rec16.size() >= 1), 1);
    if (rec16.size() >= 1) begin
      chk("t6_dat", rec16[0].dat, 0);
      chk("t6_fl", rec16[0].fl, 4'b1010);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
